fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL have parameter EXC_VECTOR, default 32'h0000_4180, the exception fetch address.
REQ-003 Clk  input  1  clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
REQ-005 IM_Req  output  1  instruction-memory read request.
REQ-006 IM_Addr  output  32  fetch address, always equal to the internal PC register.
REQ-007 IM_Ready  input  1  read data valid; a fetch completes in a cycle where IM_Req && IM_Ready.
REQ-008 IM_Rdata  input  32  instruction word, sampled only on fetch completion.
REQ-009 IF_Valid  output  1  IF/ID buffer holds an instruction.
REQ-010 IF_Instr  output  32  buffered instruction.
REQ-011 IF_PC  output  32  address of the buffered instruction.
REQ-012 ID_Ready  input  1  decode accepts IF_Instr; a hand-off occurs in a cycle where IF_Valid && ID_Ready.
REQ-013 Redirect  input  1  single-cycle pulse: branch/jump resolved in ID, taken.
REQ-014 Redirect_Target  input  32  taken target; bits [1:0] forced to 0 internally.
REQ-015 Exc  input  1  single-cycle pulse: exception, fetch restarts at EXC_VECTOR.

Function
REQ-016 The FSM SHALL have states BOOT, FETCH (buffer empty) and FULL (buffer valid); IF_Valid = (state == FULL).
REQ-017 BOOT SHALL last exactly one cycle with IM_Req=0, then go to FETCH.
REQ-018 IM_Req SHALL be 1 in FETCH, 1 in FULL only while ID_Ready=1, otherwise 0, and 0 in any cycle where Exc=1.
REQ-019 On fetch completion: IF_Instr<=IM_Rdata, IF_PC<=PC, PC<=next PC, state<=FULL (one-cycle latency, 1 instr/cycle sustained).
REQ-020 next PC SHALL be Pend_Target if Pend_Valid, else PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); Pend_Valid cleared when used.
REQ-021 In FULL with hand-off and no fetch completion, state SHALL go to FETCH; without hand-off the buffer and PC SHALL hold.
REQ-022 Redirect (delay-slot mode) with state FULL or a fetch completing this cycle SHALL load PC<=Redirect_Target, overriding REQ-020.
REQ-023 Redirect (delay-slot mode) with state FETCH and no fetch completing SHALL set Pend_Target<=Redirect_Target, Pend_Valid<=1; PC unchanged.
REQ-024 Exc SHALL discard any completing fetch, clear the buffer (state FETCH), clear Pend_Valid and load PC<=EXC_VECTOR.
REQ-025 Priority SHALL be Reset > Exc > Redirect > normal sequencing.

Reset
REQ-026 Reset SHALL set PC=RESET_PC, state=BOOT, IF_Valid=0, IF_Instr=0, IF_PC=0, Pend_Valid=0, Pend_Target=0, IM_Req=0, regardless of outstanding requests or pulses in the same cycle.

Configuration
REQ-027 With macro FETCH_CTRL_DELAY_SLOT_EN defined, Redirect SHALL follow REQ-022/REQ-023 (one MIPS delay-slot instruction issued after the branch).
REQ-028 Without FETCH_CTRL_DELAY_SLOT_EN, Redirect SHALL discard any completing fetch, clear the buffer, load PC<=Redirect_Target, go to FETCH; Pend_Valid/Pend_Target SHALL not exist.

Structure
REQ-029 Package mips_pkg SHALL hold the FSM state typedef and default constants RESET_PC and EXC_VECTOR.
REQ-030 A single sub-module fetch_buf (one-entry IF_Instr/IF_PC holding register with load/clear) is natural; no other hierarchy.

Verification
REQ-031 Reset, then IM_Ready=1, ID_Ready=1 -> IM_Addr 0x3000, 0x3004, 0x3008 on cycles 2, 3, 4 after Reset falls; IF_Valid=1 from cycle 3, IF_PC trailing by one cycle.
REQ-032 ID_Ready=0 for 3 cycles with IF_PC=0x3004 -> IF_PC/IF_Instr stable, IM_Req=0, IM_Addr stays 0x3008.
REQ-033 Delay-slot mode, Redirect 0x3100 while FULL with IF_PC=0x3008 -> 0x3008 handed off, next IM_Addr=0x3100.
REQ-034 Delay-slot mode, Redirect 0x3200 in FETCH with IM_Ready=0 for 2 cycles -> fetch at 0x300C completes, then IM_Addr=0x3200.
REQ-035 Exc with Redirect and IM_Ready in the same cycle -> IF_Valid=0 next cycle, IM_Addr=0x4180, no pending redirect applied afterwards.
REQ-036 Macro undefined, Redirect 0x3100 while FULL -> IF_Valid=0 next cycle, next IM_Addr=0x3100; PC=0xFFFF_FFFC fetch -> next IM_Addr=0x0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and default addresses for the MIPS front end.
// Used by fetch_ctrl; the optional delay-slot mode is selected with FETCH_CTRL_DELAY_SLOT_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Instruction addresses are word aligned; low two bits are never honoured.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory request/response, IF/ID buffer and ID feedback.
// master = fetch_ctrl side, slave = memory/decode side.
interface fetch_ctrl_if;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic [31:0] IM_Rdata;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic        ID_Ready;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic        Exc;

  modport master (
    output IM_Req, IM_Addr, IF_Valid, IF_Instr, IF_PC,
    input  IM_Ready, IM_Rdata, ID_Ready, Redirect, Redirect_Target, Exc
  );

  modport slave (
    input  IM_Req, IM_Addr, IF_Valid, IF_Instr, IF_PC,
    output IM_Ready, IM_Rdata, ID_Ready, Redirect, Redirect_Target, Exc
  );
endinterface

// File: rtl/fetch_buf.sv
// One-entry IF/ID holding register for the fetched instruction and its address.
// Clear wins over load; the controller never asserts both.
module fetch_buf (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      instr_d = '0;
      pc_d    = '0;
    end else if (load) begin
      instr_d = d_instr;
      pc_d    = d_pc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry IF/ID buffer, redirect and exception restart.
// Define FETCH_CTRL_DELAY_SLOT_EN to issue one delay-slot instruction after a taken redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_ctrl_if.master  bus
);
  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  seq_pc;
  logic [31:0]  redirect_tgt;
  logic         im_req;
  logic         fetch_done;
  logic         hand_off;
  logic         buf_load;
  logic         buf_clear;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
`endif
    end
  end

  // A request in FULL is only safe when decode drains the buffer in the same cycle.
  always_comb begin
    im_req = 1'b0;
    if (!Reset && !bus.Exc) begin
      case (state_q)
        ST_FETCH: im_req = 1'b1;
        ST_FULL:  im_req = bus.ID_Ready;
        default:  im_req = 1'b0;
      endcase
    end
  end

  assign fetch_done   = im_req && bus.IM_Ready;
  assign hand_off     = (state_q == ST_FULL) && bus.ID_Ready;
  assign redirect_tgt = word_align(bus.Redirect_Target);

`ifdef FETCH_CTRL_DELAY_SLOT_EN
  assign seq_pc = pend_valid_q ? pend_target_q : (pc_q + INSTR_BYTES);
`else
  assign seq_pc = pc_q + INSTR_BYTES;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
`endif
    if (bus.Exc) begin
      state_d   = ST_FETCH;
      pc_d      = EXC_VECTOR;
      buf_clear = 1'b1;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend_valid_d = 1'b0;
`endif
    end else begin
      if (fetch_done) begin
        buf_load = 1'b1;
        pc_d     = seq_pc;
        state_d  = ST_FULL;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        pend_valid_d = 1'b0;
`endif
      end else if ((state_q == ST_BOOT) || hand_off) begin
        state_d = ST_FETCH;
      end

      if (bus.Redirect) begin
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        // The delay-slot word is already buffered or arriving now, so jump straight away;
        // otherwise remember the target until the delay-slot fetch completes.
        if ((state_q == ST_FULL) || fetch_done) begin
          pc_d = redirect_tgt;
        end else begin
          pend_valid_d  = 1'b1;
          pend_target_d = redirect_tgt;
        end
`else
        state_d   = ST_FETCH;
        pc_d      = redirect_tgt;
        buf_load  = 1'b0;
        buf_clear = 1'b1;
`endif
      end
    end
  end

  fetch_buf u_fetch_buf (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .d_instr (bus.IM_Rdata),
    .d_pc    (pc_q),
    .instr   (bus.IF_Instr),
    .pc      (bus.IF_PC)
  );

  assign bus.IM_Req   = im_req;
  assign bus.IM_Addr  = pc_q;
  assign bus.IF_Valid = (state_q == ST_FULL);

endmodule
